fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/cpu_ooo_pkg.sv | 16 +
 rtl/fetch_queue.sv | 118 +++++++++++
 2 files changed

// File: rtl/cpu_ooo_pkg.sv
// cpu_ooo_pkg: constants and types shared by the out-of-order front end.
package cpu_ooo_pkg;

   // Canonical RISC-V NOP (addi x0, x0, 0).
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Default number of fetch queue entries.
   localparam int unsigned FETCH_Q_DEPTH = 4;

   // One fetched instruction together with the address it came from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: fetches sequential instructions from a combinational instruction
// memory into a small circular buffer and hands them to decode/rename in order.
// A flush discards everything queued and restarts fetch at redirect_pc.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let a word fetched into an
// empty queue appear on the dequeue port in the same cycle.
module fetch_queue
   import cpu_ooo_pkg::*;
#(
   parameter int unsigned DEPTH    = FETCH_Q_DEPTH,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [31:0]            redirect_pc,
   output logic [31:0]            imem_addr,
   input  logic [31:0]            imem_instruction,
   output logic                   deq_valid,
   input  logic                   deq_ready,
   output logic [31:0]            deq_pc,
   output logic [31:0]            deq_instruction,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned   PW         = $clog2(DEPTH);
   localparam int unsigned   CW         = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   typedef enum logic [0:0] {StIdle, StFetch} state_e;

   state_e        state_q;
   logic [31:0]   pc_q;
   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [CW-1:0] count_q;
   fq_entry_t     mem_q [DEPTH];

   logic fetching;
   logic queue_empty;
   logic bypass_sel;
   logic deq_fire;
   logic push;
   logic mem_we;
   logic head_pop;

   assign fetching    = (state_q == StFetch) && !flush;
   assign queue_empty = (count_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
   // An empty queue forwards the word being fetched straight to the consumer.
   assign bypass_sel = fetching && queue_empty;
`else
   assign bypass_sel = 1'b0;
`endif

   assign deq_valid = !flush && (!queue_empty || bypass_sel);
   assign deq_fire  = deq_valid && deq_ready;
   // A full queue can still accept a word when the head leaves in the same cycle.
   assign push      = fetching && ((count_q != FULL_COUNT) || deq_fire);
   // A forwarded word that is consumed at once never touches storage.
   assign mem_we    = push && !(bypass_sel && deq_fire);
   assign head_pop  = deq_fire && !bypass_sel;

   assign imem_addr = pc_q;
   assign count     = count_q;

   // Select the dequeue payload: forwarded word, stored head, or idle NOP.
   always_comb begin
      deq_pc          = '0;
      deq_instruction = NOP_INSTR;
      if (bypass_sel) begin
         deq_pc          = pc_q;
         deq_instruction = imem_instruction;
      end else if (deq_valid) begin
         deq_pc          = mem_q[head_q].pc;
         deq_instruction = mem_q[head_q].instr;
      end
   end

   // Control FSM plus fetch PC, pointers and occupancy; flush outranks traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         state_q <= StFetch;
         pc_q    <= redirect_pc;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (state_q == StIdle) begin
            state_q <= StFetch;
         end
         if (push) begin
            pc_q <= pc_q + 32'd4;
         end
         if (mem_we) begin
            tail_q <= tail_q + 1'b1;
         end
         if (head_pop) begin
            head_q <= head_q + 1'b1;
         end
         count_q <= count_q + CW'(mem_we) - CW'(head_pop);
      end
   end

   // Entry storage; contents are only meaningful between head and tail.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem_q[tail_q] <= '{pc: pc_q, instr: imem_instruction};
      end
   end

endmodule
